// File: rtl/board_pkg.sv
// Shared types for the 2048 board engine: cell encoding, move directions, engine states
// and the (direction, line, position) -> cell index mapping.
package board_pkg;

  localparam int CELL_W = 4;
  localparam int GRID_N = 4;
  localparam int CELLS  = 16;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SLIDE,
    SPAWN,
    DONE
  } state_e;

  // Cell index is x*4 + y; position 0 is the leading edge of the move.
  function automatic logic [3:0] cell_idx(input dir_e dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    logic [3:0] idx;
    case (dir)
      DIR_UP:    idx = {line, pos};
      DIR_DOWN:  idx = {line, ~pos};
      DIR_RIGHT: idx = {~pos, line};
      default:   idx = {pos, line};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/board_move_engine_line_merge.sv
// Combinational 2048 slide of one 4-cell line ordered from the leading edge:
// compact toward position 0, then merge equal pairs once each, leading edge first.
module line_merge
  import board_pkg::*;
(
  input  logic [15:0] line_in,
  output logic [15:0] line_out,
  output logic        changed,
  output logic [16:0] score
);

  cell_t comp [5];
  cell_t res  [4];
  cell_t nv;
  int    n_cnt;
  int    o_cnt;
  logic  skip;

  always_comb begin
    for (int k = 0; k < 5; k++) comp[k] = '0;
    for (int k = 0; k < 4; k++) res[k] = '0;
    n_cnt = 0;
    o_cnt = 0;
    skip  = 1'b0;
    nv    = '0;
    score = '0;

    for (int i = 0; i < 4; i++) begin
      if (line_in[i*CELL_W +: CELL_W] != '0) begin
        for (int k = 0; k < 4; k++)
          if (k == n_cnt) comp[k] = line_in[i*CELL_W +: CELL_W];
        n_cnt = n_cnt + 1;
      end
    end

    // comp[4] is always empty, so the lookahead at i = 3 never pairs.
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i+1] == comp[i]) begin
          nv    = (comp[i] == 4'hF) ? 4'hF : comp[i] + 4'd1;
          score = score + (17'd1 << nv);
          skip  = 1'b1;
        end else begin
          nv = comp[i];
        end
        for (int k = 0; k < 4; k++)
          if (k == o_cnt) res[k] = nv;
        o_cnt = o_cnt + 1;
      end
    end
  end

  always_comb begin
    line_out = '0;
    for (int k = 0; k < 4; k++) line_out[k*CELL_W +: CELL_W] = res[k];
  end

  assign changed = (line_out != line_in);

endmodule

// File: rtl/board_move_engine.sv
// 2048 board owner: one slide/merge move per accept (4 SLIDE cycles, then 1..16 SPAWN cycles if changed).
// Moves are only taken while move_ready; optional `BOARD_SCORE_EN adds a saturating 20-bit score.
module board_move_engine
  import board_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned WIN_EXP     = 11,
  parameter logic [3:0]  SPAWN4_MASK = 4'hF
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    move_valid,
  input  logic [1:0]              move_dir,
  output logic                    move_ready,
  input  logic                    load_en,
  input  logic [CELLS*CELL_W-1:0] load_board,
  output logic [CELLS*CELL_W-1:0] board,
  output logic                    move_done,
  output logic                    board_changed,
  output logic                    game_won,
  output logic                    game_over
`ifdef BOARD_SCORE_EN
  ,
  output logic [19:0]             score
`endif
);

  state_e      state, state_nxt;
  logic [15:0] lfsr;
  dir_e        dir_q;
  logic [1:0]  line_q;
  logic        changed_q, changed_nxt;
  logic [1:0]  init_cnt;
  logic [3:0]  scan_ptr, scan_cnt, cur_ptr;
  logic        cell_empty, scan_last, scan_exit;
  cell_t       spawn_val;
  logic [15:0] line_in, line_out;
  logic        line_chg;
  logic [16:0] line_score;

  always_comb begin
    line_in = '0;
    for (int j = 0; j < GRID_N; j++)
      line_in[j*CELL_W +: CELL_W] = board[{cell_idx(dir_q, line_q, 2'(j)), 2'b00} +: CELL_W];
  end

  line_merge u_line_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .changed  (line_chg),
    .score    (line_score)
  );

  // The scan starts from the LFSR on its first cycle, then walks the saved pointer.
  assign cur_ptr     = (scan_cnt == 4'd0) ? lfsr[3:0] : scan_ptr;
  assign cell_empty  = (board[{cur_ptr, 2'b00} +: CELL_W] == '0);
  assign scan_last   = (scan_cnt == 4'd15);
  assign scan_exit   = cell_empty || scan_last;
  assign spawn_val   = ((lfsr[7:4] & SPAWN4_MASK) == 4'd0) ? cell_t'(2) : cell_t'(1);
  assign changed_nxt = changed_q | ((state == SLIDE) && line_chg);
  assign move_ready  = (state == IDLE);
  assign move_done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    state_nxt = (init_cnt == 2'd2) ? IDLE : SPAWN;
      IDLE:    if (!load_en && move_valid) state_nxt = SLIDE;
      SLIDE:   if (line_q == 2'd3) state_nxt = changed_nxt ? SPAWN : DONE;
      SPAWN:   if (scan_exit) state_nxt = (init_cnt != 2'd2) ? INIT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state         <= INIT;
      lfsr          <= LFSR_SEED;
      board         <= '0;
      dir_q         <= DIR_UP;
      line_q        <= '0;
      changed_q     <= 1'b0;
      init_cnt      <= '0;
      scan_ptr      <= '0;
      scan_cnt      <= '0;
      board_changed <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        IDLE: begin
          if (load_en) begin
            board <= load_board;
          end else if (move_valid) begin
            dir_q     <= dir_e'(move_dir);
            line_q    <= '0;
            changed_q <= 1'b0;
          end
        end
        SLIDE: begin
          for (int j = 0; j < GRID_N; j++)
            board[{cell_idx(dir_q, line_q, 2'(j)), 2'b00} +: CELL_W] <= line_out[j*CELL_W +: CELL_W];
          line_q    <= line_q + 2'd1;
          changed_q <= changed_nxt;
        end
        SPAWN: begin
          if (cell_empty) board[{cur_ptr, 2'b00} +: CELL_W] <= spawn_val;
          if (scan_exit) begin
            scan_cnt <= '0;
            if (init_cnt != 2'd2) init_cnt <= init_cnt + 2'd1;
          end else begin
            scan_ptr <= cur_ptr + 4'd1;
            scan_cnt <= scan_cnt + 4'd1;
          end
        end
        default: ;
      endcase
      if (state_nxt == DONE) board_changed <= changed_nxt;
    end
  end

  always_comb begin
    game_won = 1'b0;
    for (int i = 0; i < CELLS; i++)
      if (32'(board[i*CELL_W +: CELL_W]) >= WIN_EXP) game_won = 1'b1;
  end

  logic has_empty, has_pair;
  always_comb begin
    has_empty = 1'b0;
    has_pair  = 1'b0;
    for (int i = 0; i < CELLS; i++)
      if (board[i*CELL_W +: CELL_W] == '0) has_empty = 1'b1;
    // Neighbours along x are GRID_N cells apart, along y they are adjacent.
    for (int x = 0; x < GRID_N - 1; x++)
      for (int y = 0; y < GRID_N; y++)
        if (board[(x*GRID_N+y)*CELL_W +: CELL_W] == board[((x+1)*GRID_N+y)*CELL_W +: CELL_W])
          has_pair = 1'b1;
    for (int x = 0; x < GRID_N; x++)
      for (int y = 0; y < GRID_N - 1; y++)
        if (board[(x*GRID_N+y)*CELL_W +: CELL_W] == board[(x*GRID_N+y+1)*CELL_W +: CELL_W])
          has_pair = 1'b1;
  end
  assign game_over = !has_empty && !has_pair;

`ifdef BOARD_SCORE_EN
  logic [20:0] score_sum;
  assign score_sum = {1'b0, score} + {4'b0, line_score};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      score <= '0;
    else if (state == IDLE && load_en)
      score <= '0;
    else if (state == SLIDE)
      score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
  end
`else
  logic unused_score;
  assign unused_score = ^line_score;
`endif

endmodule

// File: tb/tb_board_move_engine.sv
// Bench for board_move_engine: directed and randomized moves against a queue-based 2048 model.
module tb_board_move_engine;

  logic        iCLK, iRST, move_valid, move_ready, load_en;
  logic        move_done, board_changed, game_won, game_over;
  logic [1:0]  move_dir;
  logic [63:0] load_board, board;
`ifdef BOARD_SCORE_EN
  logic [19:0] score;
`endif

  int checks = 0;
  int passed = 0;

  board_move_engine dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .move_valid    (move_valid),
    .move_dir      (move_dir),
    .move_ready    (move_ready),
    .load_en       (load_en),
    .load_board    (load_board),
    .board         (board),
    .move_done     (move_done),
    .board_changed (board_changed),
    .game_won      (game_won),
    .game_over     (game_over)
`ifdef BOARD_SCORE_EN
    ,
    .score         (score)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic int cell_at(input logic [63:0] b, input int x, input int y);
    return int'(b[(x*4+y)*4 +: 4]);
  endfunction

  function automatic logic [63:0] with_cell(input logic [63:0] b, input int x, input int y,
                                            input int v);
    logic [63:0] r;
    r = b;
    r[(x*4+y)*4 +: 4] = v[3:0];
    return r;
  endfunction

  function automatic int count_nz(input logic [63:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[i*4 +: 4] != 4'd0) n++;
    return n;
  endfunction

  function automatic bit model_over(input logic [63:0] b);
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        if (cell_at(b, x, y) == 0) return 1'b0;
        if (x < 3 && cell_at(b, x, y) == cell_at(b, x+1, y)) return 1'b0;
        if (y < 3 && cell_at(b, x, y) == cell_at(b, x, y+1)) return 1'b0;
      end
    return 1'b1;
  endfunction

  function automatic bit model_won(input logic [63:0] b);
    for (int i = 0; i < 16; i++) if (int'(b[i*4 +: 4]) >= 11) return 1'b1;
    return 1'b0;
  endfunction

  // 2048 rule: collect nonzero tiles from the leading edge, merge each equal pair once.
  function automatic void model_move(input logic [63:0] b, input int dir, output logic [63:0] nb,
                                     output bit chg, output int sc);
    int xs[4];
    int ys[4];
    int q[$];
    int r[$];
    int a;
    nb = b; chg = 1'b0; sc = 0;
    for (int k = 0; k < 4; k++) begin
      q.delete(); r.delete();
      for (int j = 0; j < 4; j++) begin
        case (dir)
          0:       begin xs[j] = k;     ys[j] = j;     end
          1:       begin xs[j] = 3 - j; ys[j] = k;     end
          2:       begin xs[j] = k;     ys[j] = 3 - j; end
          default: begin xs[j] = j;     ys[j] = k;     end
        endcase
        if (cell_at(b, xs[j], ys[j]) != 0) q.push_back(cell_at(b, xs[j], ys[j]));
      end
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a) begin
          void'(q.pop_front());
          a = (a < 15) ? a + 1 : 15;
          sc += (1 << a);
        end
        r.push_back(a);
      end
      while (r.size() < 4) r.push_back(0);
      for (int j = 0; j < 4; j++) begin
        if (r[j] != cell_at(b, xs[j], ys[j])) chg = 1'b1;
        nb = with_cell(nb, xs[j], ys[j], r[j]);
      end
    end
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (move_ready !== 1'b1 && guard < 60) begin
      @(negedge iCLK);
      guard++;
    end
  endtask

  task automatic do_load(input logic [63:0] b);
    wait_ready();
    load_en = 1'b1; load_board = b;
    @(negedge iCLK);
    load_en = 1'b0;
  endtask

  task automatic run_move(input int dir, output int lat, output bit to);
    wait_ready();
    move_valid = 1'b1; move_dir = dir[1:0];
    lat = 0; to = 1'b0;
    forever begin
      @(negedge iCLK);
      lat++;
      if (lat == 1) move_valid = 1'b0;
      if (move_done === 1'b1) break;
      if (lat >= 40) begin to = 1'b1; break; end
    end
  endtask

  task automatic check_move(input string name, input logic [63:0] b0, input int dir);
    logic [63:0] nb;
    bit chg, to, bad;
    int sc, lat, spawns, a, e;
`ifdef BOARD_SCORE_EN
    longint exp_score;
    exp_score = longint'(score);
`endif
    model_move(b0, dir, nb, chg, sc);
    run_move(dir, lat, to);
    checks++;
    if (to) $display("FAIL %s_done: no move_done after %0d cycles, required within 21", name, lat);
    else passed++;
    checks++;
    if ((chg && (lat < 6 || lat > 21)) || (!chg && lat != 5))
      $display("FAIL %s_latency: got %0d cycles, required %s", name, lat, chg ? "6..21" : "5");
    else passed++;
    checks++;
    if (board_changed !== chg)
      $display("FAIL %s_changed: board_changed=%b, required %b", name, board_changed, chg);
    else passed++;
    spawns = 0; bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = int'(board[i*4 +: 4]);
      e = int'(nb[i*4 +: 4]);
      if (e != 0 || !chg) begin
        if (a != e) bad = 1'b1;
      end else if (a != 0) begin
        spawns++;
        if (a != 1 && a != 2) bad = 1'b1;
      end
    end
    if (chg && spawns != 1) bad = 1'b1;
    if ($isunknown(board)) bad = 1'b1;
    checks++;
    if (bad) $display("FAIL %s_board: got %h, required %h plus %0d spawn(s) of 1/2",
                      name, board, nb, chg ? 1 : 0);
    else passed++;
`ifdef BOARD_SCORE_EN
    exp_score += sc;
    if (exp_score > 64'hFFFFF) exp_score = 64'hFFFFF;
    checks++;
    if (longint'(score) != exp_score)
      $display("FAIL %s_score: got %0d, required %0d", name, score, exp_score);
    else passed++;
`endif
    @(negedge iCLK);
    checks++;
    if (move_done !== 1'b0) $display("FAIL %s_pulse: move_done=%b one cycle later, required 0", name, move_done);
    else passed++;
  endtask

  task automatic test_reset();
    int guard = 0;
    bit okv = 1'b1;
    iRST = 1'b1; move_valid = 1'b0; load_en = 1'b0; move_dir = 2'd0; load_board = '0;
    repeat (3) @(negedge iCLK);
    checks++;
    if (board !== 64'd0) $display("FAIL reset_board: got %h, required 0", board); else passed++;
    checks++;
    if (move_ready !== 1'b0 || move_done !== 1'b0 || board_changed !== 1'b0)
      $display("FAIL reset_outputs: ready=%b done=%b changed=%b, required 0 0 0",
               move_ready, move_done, board_changed);
    else passed++;
    iRST = 1'b0;
    while (move_ready !== 1'b1 && guard < 60) begin
      @(negedge iCLK);
      guard++;
    end
    checks++;
    if (move_ready !== 1'b1) $display("FAIL init_ready: move_ready=%b after %0d cycles, required 1", move_ready, guard);
    else passed++;
    for (int i = 0; i < 16; i++)
      if (board[i*4 +: 4] > 4'd2) okv = 1'b0;
    checks++;
    if (count_nz(board) != 2 || !okv)
      $display("FAIL init_spawn: board %h has %0d tiles, required exactly 2 of value 1/2", board, count_nz(board));
    else passed++;
    checks++;
    if (board_changed !== 1'b0 || game_over !== 1'b0)
      $display("FAIL init_flags: changed=%b over=%b, required 0 0", board_changed, game_over);
    else passed++;
  endtask

  task automatic test_status();
    logic [63:0] b = '0;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) b = with_cell(b, x, y, ((x + y) % 2) ? 2 : 1);
    do_load(b);
    checks++;
    if (board !== b) $display("FAIL load_board: got %h, required %h", board, b); else passed++;
    checks++;
    if (game_over !== 1'b1 || game_won !== 1'b0)
      $display("FAIL checker_status: over=%b won=%b, required 1 0", game_over, game_won);
    else passed++;
    do_load(with_cell(b, 2, 1, 11));
    checks++;
    if (game_won !== 1'b1) $display("FAIL won_11: game_won=%b, required 1", game_won); else passed++;
    do_load(with_cell(b, 3, 3, 0));
    checks++;
    if (game_over !== 1'b0) $display("FAIL over_empty: game_over=%b, required 0", game_over); else passed++;
    do_load(with_cell(b, 1, 0, 1));
    checks++;
    if (game_over !== 1'b0) $display("FAIL over_pair: game_over=%b, required 0", game_over); else passed++;
  endtask

  task automatic test_load_priority();
    logic [63:0] b = 64'h0000_0000_0000_0301;
    int fired = 0;
    wait_ready();
    load_en = 1'b1; move_valid = 1'b1; move_dir = 2'd3; load_board = b;
    @(negedge iCLK);
    load_en = 1'b0; move_valid = 1'b0;
    repeat (8) begin
      if (move_done === 1'b1) fired++;
      @(negedge iCLK);
    end
    checks++;
    if (board !== b || fired != 0 || move_ready !== 1'b1)
      $display("FAIL load_priority: board %h done_count %0d ready %b, required %h 0 1", board, fired, move_ready, b);
    else passed++;
  endtask

  task automatic test_row_merge();
    logic [63:0] b = '0;
    for (int x = 0; x < 4; x++) b = with_cell(b, x, 0, 1);
    do_load(b);
    check_move("row_left", b, 3);
    checks++;
    if (cell_at(board, 0, 0) != 2 || cell_at(board, 1, 0) != 2 || count_nz(board) != 3)
      $display("FAIL row_values: x0=%0d x1=%0d tiles=%0d, required 2 2 3",
               cell_at(board, 0, 0), cell_at(board, 1, 0), count_nz(board));
    else passed++;
  endtask

  task automatic test_col_merge();
    logic [63:0] b = '0;
    b = with_cell(b, 0, 0, 2);
    b = with_cell(b, 0, 2, 2);
    b = with_cell(b, 0, 3, 2);
    do_load(b);
    check_move("col_up", b, 0);
    checks++;
    if (cell_at(board, 0, 0) != 3 || cell_at(board, 0, 1) != 2)
      $display("FAIL col_values: y0=%0d y1=%0d, required 3 2", cell_at(board, 0, 0), cell_at(board, 0, 1));
    else passed++;
`ifdef BOARD_SCORE_EN
    checks++;
    if (score !== 20'd8) $display("FAIL col_score: got %0d, required 8", score); else passed++;
`endif
  endtask

  task automatic test_saturate();
    logic [63:0] b = '0;
    b = with_cell(b, 0, 1, 15);
    b = with_cell(b, 1, 1, 15);
    do_load(b);
    check_move("sat_left", b, 3);
    checks++;
    if (cell_at(board, 0, 1) != 15) $display("FAIL sat_value: got %0d, required 15", cell_at(board, 0, 1));
    else passed++;
  endtask

  task automatic test_no_change();
    logic [63:0] b = '0;
    b = with_cell(b, 0, 0, 1); b = with_cell(b, 1, 0, 2);
    b = with_cell(b, 0, 1, 3);
    b = with_cell(b, 0, 3, 5); b = with_cell(b, 1, 3, 6); b = with_cell(b, 2, 3, 7);
    do_load(b);
    check_move("nochange_left", b, 3);
    checks++;
    if (board !== b) $display("FAIL nochange_board: got %h, required %h", board, b); else passed++;
  endtask

  task automatic test_busy_ignore();
    logic [63:0] b = '0;
    int lat = 0;
    int extra = 0;
    b = with_cell(b, 1, 2, 3);
    b = with_cell(b, 3, 2, 3);
    do_load(b);
    move_valid = 1'b1; move_dir = 2'd1;
    forever begin
      @(negedge iCLK);
      lat++;
      if (lat == 2) move_dir = 2'd0;
      if (move_done === 1'b1 || lat >= 40) break;
    end
    move_valid = 1'b0;
    checks++;
    if (move_done !== 1'b1 || cell_at(board, 3, 2) != 4 || board_changed !== 1'b1)
      $display("FAIL busy_move: done=%b x3y2=%0d changed=%b, required 1 4 1",
               move_done, cell_at(board, 3, 2), board_changed);
    else passed++;
    repeat (25) begin
      @(negedge iCLK);
      if (move_done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || move_ready !== 1'b1)
      $display("FAIL busy_ignored: extra done=%0d ready=%b, required 0 1", extra, move_ready);
    else passed++;
  endtask

  task automatic test_random();
    logic [63:0] b;
    int r;
    for (int it = 0; it < 25; it++) begin
      b = '0;
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4 && (it % 5) != 0) b[i*4 +: 4] = 4'd0;
        else if (r == 9) b[i*4 +: 4] = 4'd11;
        else b[i*4 +: 4] = 4'($urandom_range(1, 4));
      end
      do_load(b);
      checks++;
      if (game_over !== model_over(b) || game_won !== model_won(b))
        $display("FAIL rand_status%0d: over=%b won=%b, required %b %b", it, game_over, game_won,
                 model_over(b), model_won(b));
      else passed++;
      check_move($sformatf("rand%0d", it), b, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] b = '0;
    int guard = 0;
    bit saw_done = 1'b0;
    for (int x = 0; x < 4; x++) b = with_cell(b, x, 0, 1);
    do_load(b);
    move_valid = 1'b1; move_dir = 2'd3;
    @(negedge iCLK);
    move_valid = 1'b0;
    @(negedge iCLK);
    iRST = 1'b1;
    #1;
    checks++;
    if (board !== 64'd0 || move_ready !== 1'b0 || move_done !== 1'b0)
      $display("FAIL midreset_async: board %h ready %b done %b, required 0 0 0", board, move_ready, move_done);
    else passed++;
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    while (move_ready !== 1'b1 && guard < 60) begin
      @(negedge iCLK);
      guard++;
      if (move_done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || move_ready !== 1'b1)
      $display("FAIL midreset_done: saw move_done=%b ready=%b, required 0 1", saw_done, move_ready);
    else passed++;
    checks++;
    if (count_nz(board) != 2 || board_changed !== 1'b0)
      $display("FAIL midreset_init: tiles=%0d changed=%b, required 2 0", count_nz(board), board_changed);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_status();
    test_load_priority();
    test_row_merge();
    test_col_merge();
    test_saturate();
    test_no_change();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/board_move_engine.md
Name: board_move_engine

Overview:
- Owns the 4x4 2048 game board as 16 registered 4-bit exponent cells: 0 = empty, n = tile value 2^n.
- Executes one slide/merge move per handshake, then spawns a new tile at a pseudo-random empty cell.
- Drives the flat board bus consumed directly by the per-cell block renderers and the colour stage.
- Cell index i maps to column x = i/4 and row y = i%4, matching the renderer placement.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the 16-bit spawn LFSR; must be nonzero.
- WIN_EXP, 11, exponent that asserts game_won (11 = tile 2048).
- SPAWN4_MASK, 4'hF, a spawned tile is exponent 2 when (lfsr[7:4] & SPAWN4_MASK) == 0, otherwise exponent 1.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous reset, active-high.
- move_valid  in  1  move request.
- move_dir  in  2  0 = up (toward y=0), 1 = right (toward x=3), 2 = down (toward y=3), 3 = left (toward x=0).
- move_ready  out  1  engine is idle and accepts a move or load.
- load_en  in  1  overwrite the board with load_board (new game / test).
- load_board  in  64  cell i occupies bits [4i+3:4i].
- board  out  64  registered board, same packing as load_board.
- move_done  out  1  one-cycle pulse when a move completes.
- board_changed  out  1  result of the last move; valid from move_done until the next accept.
- game_won  out  1  some cell >= WIN_EXP; combinational from board.
- game_over  out  1  no empty cell and no equal orthogonal neighbours; combinational from board.

Behaviour:
- Reset values: board = 0, LFSR = LFSR_SEED, state INIT with spawn count 0, move_ready = 0, move_done = 0, board_changed = 0.
- Reset is asynchronous; asserting it mid-move aborts the move and discards any partial result.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, advances every cycle in every state.
- States:
  - INIT: runs SPAWN twice, then goes to IDLE.
  - IDLE: move_ready = 1. load_en has priority over move_valid in the same cycle. load_en writes board next cycle and stays IDLE, with no spawn and no move_done. move_valid latches move_dir, clears the changed accumulator, and goes to SLIDE with line = 0.
  - SLIDE: processes one line (4 cells) per cycle, lines 0..3, so 4 cycles total.
    - Up/down: line k is column x = k. Left/right: line k is row y = k.
    - Cells are ordered from the leading edge of the move direction.
    - All nonzero tiles are compacted toward the leading edge. Equal adjacent pairs merge leading-edge first; a merged tile does not merge again in the same move. Examples: [1,1,1,1] -> [2,2,0,0]; [1,1,2,0] -> [2,2,0,0]; [2,0,2,2] -> [3,2,0,0].
    - Merge result is exponent + 1, saturating at 15.
    - changed |= (line output != line input).
    - After line 3: go to SPAWN if changed, else DONE.
  - SPAWN: start pointer p = lfsr[3:0], scanning one cell per cycle with p = (p + 1) mod 16. The first empty cell receives the spawn value (exponent 1 or 2 per SPAWN4_MASK). If 16 cells are scanned without finding an empty one, nothing is written. Scan length is 1..16 cycles.
  - DONE: move_done = 1 for exactly one cycle, board_changed = changed, then IDLE.
- Latency:
  - Unchanged move: accept, 4 SLIDE cycles, DONE; move_done arrives 5 cycles after accept.
  - Changed move: adds 1..16 SPAWN cycles.
- move_valid while move_ready = 0 is ignored; it is neither queued nor an error.
- board updates only in SLIDE, SPAWN, INIT, and IDLE load. The renderer may sample it at any time.

Optional Feature:
- BOARD_SCORE_EN defined:
  - Adds output score (20 bits). It resets to 0 and is cleared on load_en.
  - Each merge adds 2^(new exponent).
  - score saturates at 20'hFFFFF.
  - score updates in the same cycle as the merging SLIDE line.
- BOARD_SCORE_EN undefined: no score port and no score logic.

Decomposition:
- Package board_pkg holds:
  - CELL_W = 4, GRID_N = 4, CELLS = 16;
  - move direction enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT);
  - state enum (INIT, IDLE, SLIDE, SPAWN, DONE);
  - cell_t typedef;
  - function mapping (direction, line, position) to cell index.
- Sub-module line_merge: purely combinational.
  - Inputs: 4 cell_t values ordered from the leading edge.
  - Outputs: 4 cell_t values, changed flag, and merge score sum.
  - Instantiated once and reused across the 4 SLIDE cycles.

Test Plan:
- Reset release: after INIT, exactly 2 nonzero cells, each value 1 or 2; then move_ready = 1 and board_changed = 0.
- Load a board where row y=0 is [1,1,1,1] and all other cells are 0, then move left: row y=0 becomes [2,2,0,0]; exactly one new cell with value 1 or 2 appears elsewhere; board_changed = 1; move_done arrives 6..21 cycles after accept.
- Load column x=0 as [2,0,2,2] (y=0..3), everything else 0, then move up: column becomes [3,2,0,0] plus one spawn. With BOARD_SCORE_EN, score = 8.
- Load a board already compacted left with no merges possible, then move left: board unchanged, no spawn, board_changed = 0, move_done exactly 5 cycles after accept.
- Load a checkerboard of 1 and 2 with no empty cells: game_over = 1 and game_won = 0. Load any cell = 11: game_won = 1.
- Assert iRST on the 2nd SLIDE cycle: board = 0 immediately (asynchronous), move_done never fires, and the INIT sequence reruns after release.
